// File: rtl/wb_uart.sv
// Wishbone-pipelined UART: TX and RX shifters, each with its own circular FIFO,
// a programmable bit divisor, sticky error flags and a registered level interrupt.
module wb_uart #(
    parameter int          FifoDepth      = 16,
    parameter logic [15:0] DefaultDivisor = 16'd434
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        irq_o,
    output logic [31:0] wb_data_o,
    output logic        wb_ack_o,
    output logic        wb_stall_o,
    output logic        wb_err_o,
    input  logic [31:0] wb_data_i,
    input  logic [29:0] wb_addr_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i
);
    localparam int AW = $clog2(FifoDepth);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    logic        req, wr, rd;
    logic [1:0]  reg_sel;
    logic        data_wr, status_wr, div_wr, irq_en_wr;
    logic [15:0] divisor, div_new;
    logic [1:0]  irq_en;
    logic        rx_overrun, frame_err;
    logic [31:0] read_mux, status;
    logic        unused_bits;

    assign req       = wb_cyc_i & wb_stb_i;
    assign wr        = req & wb_we_i;
    assign rd        = req & ~wb_we_i;
    assign reg_sel   = wb_addr_i[1:0];
    assign data_wr   = wr & wb_sel_i[0] & (reg_sel == 2'd0);
    assign status_wr = wr & wb_sel_i[0] & (reg_sel == 2'd1);
    assign div_wr    = wr & wb_sel_i[0] & (reg_sel == 2'd2);
    assign irq_en_wr = wr & wb_sel_i[0] & (reg_sel == 2'd3);
    assign wb_stall_o  = 1'b0;
    assign unused_bits = ^{wb_addr_i[29:2], wb_data_i[31:16], wb_sel_i[3:2]};

    // ---------------- TX FIFO ----------------
    logic [7:0]  tx_mem [FifoDepth];
    logic [AW:0] tx_wp, tx_rp;
    logic        tx_empty, tx_full, tx_push, tx_pop, tx_reject;

    assign tx_empty  = (tx_wp == tx_rp);
    assign tx_full   = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign tx_push   = data_wr & (~tx_full | tx_pop);
    assign tx_reject = data_wr & tx_full & ~tx_pop;

    always_ff @(posedge clk_i) begin
        if (tx_push)
            tx_mem[tx_wp[AW-1:0]] <= wb_data_i[7:0];
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tx_wp <= '0;
            tx_rp <= '0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
        end
    end

    // ---------------- TX shifter ----------------
    state_t      tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_sh, tx_sh_n;
    logic        tx_line, tx_line_n, tx_idle;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_div   <= DefaultDivisor;
            tx_bit   <= '0;
            tx_sh    <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
            tx_line  <= tx_line_n;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_line_n  = tx_line;
        tx_pop     = 1'b0;
        case (tx_state)
            S_IDLE: begin
                tx_line_n = 1'b1;
                tx_pop    = ~tx_empty;
            end
            S_START: begin
                if (tx_cnt == 16'd0) begin
                    tx_state_n = S_DATA;
                    tx_cnt_n   = tx_div - 16'd1;
                    tx_bit_n   = 3'd0;
                    tx_line_n  = tx_sh[0];
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt_n = tx_div - 16'd1;
                    if (tx_bit == 3'd7) begin
                        tx_state_n = S_STOP;
                        tx_line_n  = 1'b1;
                    end else begin
                        tx_bit_n  = tx_bit + 3'd1;
                        tx_sh_n   = tx_sh >> 1;
                        tx_line_n = tx_sh[1];
                    end
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (tx_cnt == 16'd0) begin
                    tx_state_n = S_IDLE;
                    tx_line_n  = 1'b1;
                    tx_pop     = ~tx_empty;
                end else begin
                    tx_cnt_n = tx_cnt - 16'd1;
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
        // Starting a frame latches the divisor so mid-frame writes wait a frame.
        if (tx_pop) begin
            tx_state_n = S_START;
            tx_div_n   = divisor;
            tx_cnt_n   = divisor - 16'd1;
            tx_sh_n    = tx_mem[tx_rp[AW-1:0]];
            tx_line_n  = 1'b0;
        end
    end

    assign tx_o    = tx_line;
    assign tx_idle = tx_empty & (tx_state == S_IDLE);

    // ---------------- RX synchronizer and shifter ----------------
    logic [1:0]  rx_sync;
    logic        rx_prev, rx_s, rx_fall;
    state_t      rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_sh, rx_sh_n;
    logic        rx_done, rx_done_n, ferr_set;

    assign rx_s    = rx_sync[1];
    assign rx_fall = rx_prev & ~rx_s;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= DefaultDivisor;
            rx_bit   <= '0;
            rx_sh    <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rx_i};
            rx_prev  <= rx_s;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
            rx_done  <= rx_done_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_done_n  = 1'b0;
        ferr_set   = 1'b0;
        case (rx_state)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_state_n = S_START;
                    rx_div_n   = divisor;
                    rx_cnt_n   = {1'b0, divisor[15:1]} - 16'd1;
                end
            end
            S_START: begin
                if (rx_cnt == 16'd0) begin
                    if (rx_s) begin
                        rx_state_n = S_IDLE;
                    end else begin
                        rx_state_n = S_DATA;
                        rx_cnt_n   = rx_div - 16'd1;
                        rx_bit_n   = 3'd0;
                    end
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (rx_cnt == 16'd0) begin
                    rx_sh_n  = {rx_s, rx_sh[7:1]};
                    rx_cnt_n = rx_div - 16'd1;
                    if (rx_bit == 3'd7) rx_state_n = S_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (rx_cnt == 16'd0) begin
                    rx_state_n = S_IDLE;
                    rx_done_n  = rx_s;
                    ferr_set   = ~rx_s;
                end else begin
                    rx_cnt_n = rx_cnt - 16'd1;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]  rx_mem [FifoDepth];
    logic [AW:0] rx_wp, rx_rp;
    logic        rx_empty, rx_full, rx_push, rx_pop, ovr_set;

    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign rx_pop   = rd & (reg_sel == 2'd0) & ~rx_empty;
    assign rx_push  = rx_done & (~rx_full | rx_pop);
    assign ovr_set  = rx_done & rx_full & ~rx_pop;

    always_ff @(posedge clk_i) begin
        if (rx_push)
            rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        end
    end

    // ---------------- Control registers ----------------
    assign div_new = {wb_sel_i[1] ? wb_data_i[15:8] : divisor[15:8], wb_data_i[7:0]};

    // A new error event wins over a same-cycle write-one-to-clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            divisor    <= DefaultDivisor;
            irq_en     <= 2'b00;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            if (div_wr)
                divisor <= (div_new < 16'd4) ? 16'd4 : div_new;
            if (irq_en_wr)
                irq_en <= wb_data_i[1:0];
            if (ovr_set)
                rx_overrun <= 1'b1;
            else if (status_wr & wb_data_i[3])
                rx_overrun <= 1'b0;
            if (ferr_set)
                frame_err <= 1'b1;
            else if (status_wr & wb_data_i[4])
                frame_err <= 1'b0;
        end
    end

    // ---------------- Bus response and interrupt ----------------
    assign status = {27'd0, frame_err, rx_overrun, tx_idle, tx_full, ~rx_empty};

    always_comb begin
        read_mux = 32'd0;
        case (reg_sel)
            2'd0:    read_mux = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp[AW-1:0]]};
            2'd1:    read_mux = status;
            2'd2:    read_mux = {16'd0, divisor};
            default: read_mux = {30'd0, irq_en};
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wb_ack_o  <= 1'b0;
            wb_err_o  <= 1'b0;
            wb_data_o <= 32'd0;
            irq_o     <= 1'b0;
        end else begin
            wb_ack_o  <= req & ~tx_reject;
            wb_err_o  <= tx_reject;
            wb_data_o <= rd ? read_mux : 32'd0;
            irq_o     <= (irq_en[0] & ~rx_empty) | (irq_en[1] & tx_empty);
        end
    end
endmodule

// File: tb/tb_wb_uart.sv
// Self-checking bench for wb_uart: randomized directed steps compared against a
// queue-based model of the register map, serial framing and FIFO capacity.
module tb_wb_uart;
    localparam int          FD    = 4;
    localparam logic [15:0] DDIV  = 16'd434;

    logic        clk, rst, rx_drv, loop;
    logic        rx_line, tx_o, irq_o;
    logic [31:0] wb_data_o, wb_data_i;
    logic        wb_ack_o, wb_stall_o, wb_err_o;
    logic [29:0] wb_addr_i;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic [15:0] m_div;
    logic [1:0]  m_en;
    logic        m_ovr, m_ferr;
    byte unsigned rx_q[$];
    byte unsigned exp_tx[$];
    byte unsigned tx_seen[$];
    int          mon_div = 16;
    logic        mon_en  = 1'b0;

    logic [31:0] rdata;
    logic        ack, err;

    assign rx_line = loop ? tx_o : rx_drv;

    wb_uart #(.FifoDepth(FD), .DefaultDivisor(DDIV)) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .rx_i       (rx_line),
        .tx_o       (tx_o),
        .irq_o      (irq_o),
        .wb_data_o  (wb_data_o),
        .wb_ack_o   (wb_ack_o),
        .wb_stall_o (wb_stall_o),
        .wb_err_o   (wb_err_o),
        .wb_data_i  (wb_data_i),
        .wb_addr_i  (wb_addr_i),
        .wb_sel_i   (wb_sel_i),
        .wb_cyc_i   (wb_cyc_i),
        .wb_stb_i   (wb_stb_i),
        .wb_we_i    (wb_we_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] status_exp();
        return {27'd0, m_ferr, m_ovr, 1'b1, 1'b0, (rx_q.size() != 0)};
    endfunction

    // One single-cycle Wishbone request; response sampled 1ns after the next edge.
    task automatic wb_xfer(input logic [1:0] a, input logic we, input logic [31:0] d,
                           input logic [3:0] s, output logic [31:0] rd,
                           output logic ak, output logic er);
        @(negedge clk);
        wb_cyc_i  = 1'b1;
        wb_stb_i  = 1'b1;
        wb_we_i   = we;
        wb_addr_i = {28'd0, a};
        wb_data_i = d;
        wb_sel_i  = s;
        @(posedge clk);
        #1;
        rd = wb_data_o;
        ak = wb_ack_o;
        er = wb_err_o;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wb_write(input string tag, input logic [1:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        logic [31:0] rd;
        logic ak, er;
        wb_xfer(a, 1'b1, d, s, rd, ak, er);
        check_output({tag, "_ack"}, 32'(ak), 32'd1);
    endtask

    task automatic wb_read_check(input string tag, input logic [1:0] a, input logic [31:0] expv);
        logic [31:0] rd;
        logic ak, er;
        wb_xfer(a, 1'b0, 32'd0, 4'hF, rd, ak, er);
        check_output(tag, rd, expv);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div);
        logic [9:0] bits;
        bits = {stop_bit, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            repeat (div) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_div  = DDIV;
        m_en   = 2'b00;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        rx_q.delete();
    endtask

    // Independent serial receiver watching tx_o, sampling at mid-bit.
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && tx_o === 1'b0) begin
                repeat (mon_div / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clk);
                    b[i] = tx_o;
                end
                repeat (mon_div) @(negedge clk);
                tx_seen.push_back(b);
            end
        end
    end

    initial begin
        logic [7:0]  b;
        logic [9:0]  fb;
        logic [15:0] v, nd;
        logic        s1, exp_ok;
        int          accepted, t;

        wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
        wb_addr_i = '0; wb_data_i = '0; wb_sel_i = '0;
        rx_drv = 1'b1; loop = 1'b0; rst = 1'b1;
        m_div = DDIV; m_en = 0; m_ovr = 0; m_ferr = 0;

        // reset values
        repeat (3) @(negedge clk);
        check_output("rst_tx", 32'(tx_o), 32'd1);
        check_output("rst_irq", 32'(irq_o), 32'd0);
        check_output("rst_ack", 32'(wb_ack_o), 32'd0);
        check_output("rst_err", 32'(wb_err_o), 32'd0);
        check_output("rst_data", wb_data_o, 32'd0);
        check_output("stall", 32'(wb_stall_o), 32'd0);
        rst = 1'b0;
        wb_read_check("rst_status", 2'd1, 32'h04);
        wb_read_check("rst_div", 2'd2, 32'(DDIV));
        wb_read_check("rst_irqen", 2'd3, 32'd0);

        // DIVISOR: clamp to 4, byte-lane masking, sel[0]=0 ignored
        for (int i = 0; i < 6; i++) begin
            if (i < 2) begin
                v  = 16'($urandom_range(0, 3));
                s1 = 1'b1;
            end else begin
                v  = 16'($urandom);
                s1 = 1'($urandom_range(0, 1));
            end
            nd = {s1 ? v[15:8] : m_div[15:8], v[7:0]};
            m_div = (nd < 16'd4) ? 16'd4 : nd;
            wb_write("div_wr", 2'd2, {16'hBEEF, v}, {2'b00, s1, 1'b1});
            wb_read_check("div_rd", 2'd2, 32'(m_div));
        end
        wb_write("div_nosel", 2'd2, 32'($urandom), 4'b0010);
        wb_read_check("div_nosel_rd", 2'd2, 32'(m_div));

        // TX waveform at DIVISOR=4
        wb_write("div4", 2'd2, 32'd4, 4'b0011);
        m_div = 16'd4;
        for (int n = 0; n < 2; n++) begin
            b  = (n == 0) ? 8'hA5 : 8'($urandom);
            fb = {1'b1, b, 1'b0};
            wb_write("tx_data", 2'd0, {24'd0, b}, 4'b0001);
            @(posedge clk); #1;
            for (int k = 0; k < 40; k++) begin
                check_output("tx_bit", 32'(tx_o), 32'(fb[k / 4]));
                @(posedge clk); #1;
            end
            check_output("tx_line_idle", 32'(tx_o), 32'd1);
            wb_read_check("tx_idle_status", 2'd1, 32'h04);
        end

        // loopback at DIVISOR=8
        wb_write("div8", 2'd2, 32'd8, 4'b0011);
        m_div = 16'd8;
        loop = 1'b1;
        for (int n = 0; n < 2; n++) begin
            b = (n == 0) ? 8'h3C : 8'($urandom);
            wb_write("loop_tx", 2'd0, {24'd0, b}, 4'b0001);
            rx_q.push_back(b);
            repeat (10 * 8 + 20) @(negedge clk);
            wb_read_check("loop_status1", 2'd1, status_exp());
            wb_read_check("loop_data", 2'd0, 32'(rx_q.pop_front()));
            wb_read_check("loop_status2", 2'd1, status_exp());
        end
        loop = 1'b0;

        // RX overrun with a 4-deep FIFO
        for (int n = 0; n < 5; n++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 8);
            repeat (4) @(negedge clk);
            if (rx_q.size() < FD) rx_q.push_back(b);
            else                  m_ovr = 1'b1;
        end
        wb_read_check("ovr_status", 2'd1, status_exp());
        for (int n = 0; n < FD; n++)
            wb_read_check("ovr_data", 2'd0, 32'(rx_q.pop_front()));
        wb_read_check("empty_data", 2'd0, 32'd0);
        wb_write("ovr_clr", 2'd1, 32'h08, 4'b0001);
        m_ovr = 1'b0;
        wb_read_check("ovr_cleared", 2'd1, status_exp());

        // frame error, then a one-clock glitch
        send_frame(8'($urandom), 1'b0, 8);
        repeat (6) @(negedge clk);
        m_ferr = 1'b1;
        wb_read_check("ferr_status", 2'd1, status_exp());
        wb_write("ferr_clr", 2'd1, 32'h10, 4'b0001);
        m_ferr = 1'b0;
        wb_read_check("ferr_cleared", 2'd1, status_exp());
        @(negedge clk); rx_drv = 1'b0;
        @(negedge clk); rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        wb_read_check("glitch_status", 2'd1, status_exp());

        // rx_valid interrupt
        wb_write("irqen1", 2'd3, 32'd1, 4'b0001);
        m_en = 2'b01;
        repeat (2) @(negedge clk);
        check_output("irq_rx_off", 32'(irq_o), 32'(m_en[0] & (rx_q.size() != 0)));
        b = 8'($urandom);
        send_frame(b, 1'b1, 8);
        rx_q.push_back(b);
        repeat (6) @(negedge clk);
        check_output("irq_rx_on", 32'(irq_o), 32'(m_en[0] & (rx_q.size() != 0)));
        wb_read_check("irq_rx_data", 2'd0, 32'(rx_q.pop_front()));
        repeat (2) @(negedge clk);
        check_output("irq_rx_clear", 32'(irq_o), 32'(m_en[0] & (rx_q.size() != 0)));
        wb_write("irqen0", 2'd3, 32'd0, 4'b0001);
        m_en = 2'b00;

        // TX FIFO fill: six writes two cycles apart
        wb_write("div16", 2'd2, 32'd16, 4'b0011);
        m_div = 16'd16;
        mon_div = 16;
        tx_seen.delete();
        exp_tx.delete();
        mon_en = 1'b1;
        accepted = 0;
        for (int n = 0; n < 6; n++) begin
            b = 8'($urandom);
            exp_ok = ((accepted - ((accepted > 0) ? 1 : 0)) < FD);
            wb_xfer(2'd0, 1'b1, {24'd0, b}, 4'b0001, rdata, ack, err);
            check_output("fill_ack", 32'(ack), 32'(exp_ok));
            check_output("fill_err", 32'(err), 32'(!exp_ok));
            if (exp_ok) begin
                exp_tx.push_back(b);
                accepted++;
            end
            @(negedge clk);
        end
        t = 0;
        while (tx_seen.size() < exp_tx.size() && t < 6 * 10 * 16 + 200) begin
            @(negedge clk);
            t++;
        end
        check_output("fill_frames", 32'(tx_seen.size()), 32'(exp_tx.size()));
        while (tx_seen.size() > 0 && exp_tx.size() > 0)
            check_output("fill_byte", 32'(tx_seen.pop_front()), 32'(exp_tx.pop_front()));
        mon_en = 1'b0;
        repeat (20) @(negedge clk);
        wb_read_check("fill_idle", 2'd1, status_exp());

        // TX-empty interrupt and asynchronous reset in the middle of a frame
        apply_reset();
        wb_write("irqen2", 2'd3, 32'd2, 4'b0001);
        m_en = 2'b10;
        check_output("irq_lag", 32'(irq_o), 32'd0);
        @(posedge clk); #1;
        check_output("irq_tx_empty", 32'(irq_o), 32'd1);
        wb_write("div8b", 2'd2, 32'd8, 4'b0011);
        wb_write("tx_zero", 2'd0, 32'd0, 4'b0001);
        repeat (20) @(posedge clk);
        #1;
        check_output("tx_midframe", 32'(tx_o), 32'd0);
        check_output("irq_midframe", 32'(irq_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_output("async_tx", 32'(tx_o), 32'd1);
        check_output("async_irq", 32'(irq_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_div = DDIV; m_en = 0; m_ovr = 0; m_ferr = 0;
        rx_q.delete();
        wb_read_check("post_rst_status", 2'd1, status_exp());
        wb_read_check("post_rst_div", 2'd2, 32'(m_div));
        wb_read_check("post_rst_irqen", 2'd3, 32'(m_en));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
